instr_mem_prog: RTL and testbench

Parametrised, programmable instruction memory for the 16-bit core; successor to the fixed, reset-loaded instruction ROM.
- Core fetches words by byte address, as before.
- Contents are no longer hard-wired. After reset a clear sequencer zero-fills every word (0x0000 = HALT), then a valid/ready programming port loads the program.
- Adds selectable read latency, misalignment and out-of-range flags, and a saturating count of words loaded.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_clear_seq.sv | 48 ++++
 rtl/instr_mem_prog.sv | 100 ++++++++++
 tb/tb_instr_mem_prog.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants, FSM state type and helpers for the programmable instruction memory.
package imem_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam logic [INSTR_W-1:0] HALT = 16'h0000;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/imem_clear_seq.sv
// Post-reset zero-fill sequencer: walks every word once, then opens the programming port.
module imem_clear_seq
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned PTR_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             busy,
    output logic             prog_ready,
    output logic [PTR_W-1:0] ptr
);

    state_t state;

    // The edge that clears the last word also hands over to READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            ptr        <= '0;
            busy       <= 1'b1;
            prog_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (ptr == PTR_W'(DEPTH - 1)) begin
                        state      <= READY;
                        ptr        <= '0;
                        busy       <= 1'b0;
                        prog_ready <= 1'b1;
                    end else begin
                        ptr <= ptr + PTR_W'(1);
                    end
                end
                READY: begin
                    busy       <= 1'b0;
                    prog_ready <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_mem_prog.sv
// Programmable instruction memory: byte-addressed fetch, valid/ready program port,
// zero-fill after reset, optional registered fetch with misalign/out-of-range flags.
module instr_mem_prog
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W   = INSTR_W,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned READ_LAT = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ADDR_W-1:0]        ADDR,
    output logic [DATA_W-1:0]        Q,
    output logic                     misalign,
    output logic                     oob,
    output logic                     busy,
    input  logic                     prog_valid,
    output logic                     prog_ready,
    input  logic [clog2(DEPTH)-1:0]  prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic [clog2(DEPTH):0]    prog_count
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned WW = ADDR_W - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     clr_ptr;
    logic [WW-1:0]     widx;
    logic              oob_c;
    logic [DATA_W-1:0] q_c;
    logic              prog_fire;

    imem_clear_seq #(
        .DEPTH (DEPTH),
        .PTR_W (AW)
    ) u_clear_seq (
        .clk        (CLK),
        .reset      (RESET),
        .busy       (busy),
        .prog_ready (prog_ready),
        .ptr        (clr_ptr)
    );

    assign prog_fire = prog_valid & prog_ready & ~RESET;

    // Array has no reset; RESET blocks both clear and program writes.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (busy) begin
                mem[clr_ptr] <= DATA_W'(HALT);
            end else if (prog_fire) begin
                mem[prog_addr] <= prog_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prog_count <= '0;
        end else if (prog_fire && (prog_count != (AW + 1)'(DEPTH))) begin
            prog_count <= prog_count + (AW + 1)'(1);
        end
    end

    assign widx = ADDR[ADDR_W-1:1];

    generate
        if (DEPTH >= (32'd1 << WW)) begin : g_no_oob
            assign oob_c = 1'b0;
        end else begin : g_oob
            assign oob_c = (32'(widx) >= DEPTH);
        end
    endgenerate

    assign q_c = (busy | oob_c) ? '0 : mem[widx[AW-1:0]];

    // Registered variant is read-before-write and masks with same-cycle busy.
    generate
        if (READ_LAT == 0) begin : g_comb_fetch
            assign Q        = q_c;
            assign misalign = ADDR[0];
            assign oob      = oob_c;
        end else begin : g_reg_fetch
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    Q        <= '0;
                    misalign <= 1'b0;
                    oob      <= 1'b0;
                end else begin
                    Q        <= q_c;
                    misalign <= ADDR[0];
                    oob      <= oob_c;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_prog.sv
// Bench for instr_mem_prog: three instances (128/comb, 128/registered, 64/comb) on shared stimulus.
module tb_instr_mem_prog;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic        prog_valid;
    logic [6:0]  prog_addr;
    logic [15:0] prog_data;

    logic [15:0] q_a, q_b, q_c;
    logic        mis_a, mis_b, mis_c;
    logic        oob_a, oob_b, oob_c;
    logic        busy_a, busy_b, busy_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic [7:0]  cnt_a, cnt_b;
    logic [6:0]  cnt_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_mem_prog #(.DEPTH(128), .READ_LAT(0)) u_a (
        .CLK(clk), .RESET(reset), .ADDR(addr), .Q(q_a), .misalign(mis_a), .oob(oob_a),
        .busy(busy_a), .prog_valid(prog_valid), .prog_ready(rdy_a), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_count(cnt_a));

    instr_mem_prog #(.DEPTH(128), .READ_LAT(1)) u_b (
        .CLK(clk), .RESET(reset), .ADDR(addr), .Q(q_b), .misalign(mis_b), .oob(oob_b),
        .busy(busy_b), .prog_valid(prog_valid), .prog_ready(rdy_b), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_count(cnt_b));

    instr_mem_prog #(.DEPTH(64), .READ_LAT(0)) u_c (
        .CLK(clk), .RESET(reset), .ADDR(addr), .Q(q_c), .misalign(mis_c), .oob(oob_c),
        .busy(busy_c), .prog_valid(prog_valid), .prog_ready(rdy_c), .prog_addr(prog_addr[5:0]),
        .prog_data(prog_data), .prog_count(cnt_c));

    typedef struct {
        logic        wr;
        logic [6:0]  waddr;
        logic [15:0] wdata;
        logic [7:0]  faddr;
        logic [15:0] exp_q;
        logic        exp_mis;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until each instance drops busy; -1 if it never does within the bound.
    task automatic measure_clear(output int ca, output int cc);
        int n;
        n  = 0;
        ca = -1;
        cc = -1;
        while ((busy_a || busy_c) && n < 1000) begin
            step();
            n++;
            if (!busy_c && cc < 0) cc = n;
            if (!busy_a && ca < 0) ca = n;
        end
    endtask

    initial begin
        int ca, cc;

        vt[0] = '{1'b1, 7'd0,   16'hF001, 8'h00, 16'hF001, 1'b0, 8'd1};
        vt[1] = '{1'b1, 7'd5,   16'h5101, 8'h0A, 16'h5101, 1'b0, 8'd2};
        vt[2] = '{1'b0, 7'd0,   16'h0000, 8'h0B, 16'h5101, 1'b1, 8'd2};
        vt[3] = '{1'b0, 7'd0,   16'h0000, 8'h00, 16'hF001, 1'b0, 8'd2};
        vt[4] = '{1'b0, 7'd0,   16'h0000, 8'h02, 16'h0000, 1'b0, 8'd2};
        vt[5] = '{1'b1, 7'd127, 16'hABCD, 8'hFE, 16'hABCD, 1'b0, 8'd3};
        vt[6] = '{1'b0, 7'd0,   16'h0000, 8'hFF, 16'hABCD, 1'b1, 8'd3};
        vt[7] = '{1'b1, 7'd0,   16'h1111, 8'h01, 16'h1111, 1'b1, 8'd4};

        reset      = 1'b1;
        addr       = 8'h00;
        prog_valid = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        step();
        step();
        chk("rst_busy",  32'(busy_a), 32'd1);
        chk("rst_ready", 32'(rdy_a),  32'd0);
        chk("rst_count", 32'(cnt_a),  32'd0);
        chk("rst_q_reg", 32'(q_b),    32'd0);
        chk("rst_flags_reg", 32'({mis_b, oob_b}), 32'd0);

        reset = 1'b0;
        measure_clear(ca, cc);
        chk("clear_len_128", 32'(ca), 32'd128);
        chk("clear_len_64",  32'(cc), 32'd64);
        chk("ready_after_clear", 32'(rdy_a), 32'd1);

        for (int i = 0; i < 128; i++) begin
            addr = 8'(2 * i);
            #1;
            chk("sweep_zero", 32'(q_a), 32'd0);
            chk("sweep_oob64", 32'(oob_c), 32'(i >= 64));
        end

        for (int i = 0; i < 8; i++) begin
            prog_valid = vt[i].wr;
            prog_addr  = vt[i].waddr;
            prog_data  = vt[i].wdata;
            addr       = vt[i].faddr;
            step();
            prog_valid = 1'b0;
            #1;
            chk("vec_q",     32'(q_a),   32'(vt[i].exp_q));
            chk("vec_mis",   32'(mis_a), 32'(vt[i].exp_mis));
            chk("vec_oob",   32'(oob_a), 32'd0);
            chk("vec_count", 32'(cnt_a), 32'(vt[i].exp_cnt));
        end

        addr = 8'h7E;
        #1;
        chk("d64_last_word", 32'(q_c), 32'hABCD);
        addr = 8'h80;
        #1;
        chk("d64_oob_flag", 32'(oob_c), 32'd1);
        chk("d64_oob_q",    32'(q_c),   32'd0);

        // Same-cycle write and fetch of word 5.
        addr       = 8'h0A;
        prog_addr  = 7'd5;
        prog_data  = 16'h1234;
        prog_valid = 1'b1;
        #1;
        chk("rw_comb_old", 32'(q_a), 32'h5101);
        step();
        prog_valid = 1'b0;
        #1;
        chk("rw_comb_new", 32'(q_a), 32'h1234);
        chk("rw_reg_old",  32'(q_b), 32'h5101);
        step();
        chk("rw_reg_new",  32'(q_b), 32'h1234);

        // 5 writes so far; 125 more gives 130 accepted.
        for (int i = 0; i < 125; i++) begin
            prog_valid = 1'b1;
            prog_addr  = 7'(i);
            prog_data  = 16'(i);
            step();
        end
        prog_valid = 1'b0;
        chk("sat_count_128", 32'(cnt_a), 32'd128);
        chk("sat_count_64",  32'(cnt_c), 32'd64);

        reset      = 1'b1;
        prog_valid = 1'b1;
        prog_addr  = 7'd5;
        prog_data  = 16'hBEEF;
        step();
        chk("rst2_count", 32'(cnt_a), 32'd0);
        chk("rst2_busy",  32'(busy_a), 32'd1);
        chk("rst2_ready", 32'(rdy_a),  32'd0);
        reset = 1'b0;
        addr  = 8'h0A;
        #1;
        chk("busy_mask_q", 32'(q_a), 32'd0);
        for (int i = 0; i < 40; i++) step();
        chk("midclear_busy", 32'(busy_a), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        measure_clear(ca, cc);
        prog_valid = 1'b0;
        chk("reclear_len_128", 32'(ca), 32'd128);
        chk("reclear_len_64",  32'(cc), 32'd64);
        chk("ignored_count",   32'(cnt_a), 32'd0);
        chk("d64_late_writes", 32'(cnt_c), 32'd64);
        #1;
        chk("rezero_w5",     32'(q_a), 32'd0);
        chk("d64_w5_beef",   32'(q_c), 32'hBEEF);
        addr = 8'h00;
        #1;
        chk("rezero_w0", 32'(q_a), 32'd0);
        addr = 8'hFE;
        step();
        chk("rezero_w127",     32'(q_a), 32'd0);
        chk("rezero_w127_reg", 32'(q_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
